regfile_mp_sb: RTL and testbench

Parametrised multi-port register file for the pipelined RISC-V core. It has NRD combinational read ports with write-through bypass and two prioritised write ports. It also holds a per-register pending-write scoreboard that the decode stage uses for hazard detection. It replaces the fixed 3-read/1-write file, adding reset clearing, dual write-back, a hard-wired zero register option and busy tracking.

---
 rtl/regfile_mp_sb.sv | 95 +++++++++
 tb/tb_regfile_mp_sb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NRD bypassed read ports, two prioritised write ports,
// and a per-register pending-write scoreboard for decode-stage hazard detection.
module regfile_mp_sb #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NRD      = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Port 1 is applied last so it wins a same-address collision; issue beats write-back.
    always_comb begin
        busy_d = busy_q;
        for (int a = 0; a < DEPTH; a++) begin
            mem_d[a] = mem_q[a];
            if (we0 && (wa0 == ADDR_W'(a))) begin
                mem_d[a]  = wd0;
                busy_d[a] = 1'b0;
            end
            if (we1 && (wa1 == ADDR_W'(a))) begin
                mem_d[a]  = wd1;
                busy_d[a] = 1'b0;
            end
            if (iss_en && (iss_addr == ADDR_W'(a))) begin
                busy_d[a] = 1'b1;
            end
            if ((ZERO_REG != 0) && (a == 0)) begin
                mem_d[a]  = '0;
                busy_d[a] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= mem_d[a];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic              wr0_hit;
        logic              wr1_hit;
        logic [DATA_W-1:0] rdata;

        assign addr     = ra[g*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign wr0_hit  = we0 && (wa0 == addr);
        assign wr1_hit  = we1 && (wa1 == addr);

        always_comb begin
            rdata = mem_q[addr];
            if (wr0_hit) rdata = wd0;
            if (wr1_hit) rdata = wd1;
            if (zero_hit || rst) rdata = '0;
        end

        assign rd[g*DATA_W +: DATA_W] = rdata;
        // A write landing this cycle retires the pending producer, so the reader sees it free.
        assign rbusy[g] = !rst && !zero_hit && busy_q[addr] && !wr0_hit && !wr1_hit;
    end

    assign dbg_data = (rst || ((ZERO_REG != 0) && (dbg_addr == '0))) ? '0 : mem_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised + directed bench for regfile_mp_sb; instance A has a hard-wired r0,
// instance B treats r0 as an ordinary register. Both share stimulus.
module tb_regfile_mp_sb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd_a, rd_b;
    logic [NR-1:0]    rbusy_a, rbusy_b;
    logic             we0, we1, iss_en;
    logic [AW-1:0]    wa0, wa1, iss_addr, dbg_addr;
    logic [DW-1:0]    wd0, wd1, dbg_a, dbg_b;

    int n_vec = 0;
    int n_err = 0;

    // k=0 -> zero register hard-wired, k=1 -> ordinary r0
    logic [DW-1:0] mm [2][DEPTH];
    bit            bb [2][DEPTH];

    regfile_mp_sb #(.ADDR_W(AW), .DATA_W(DW), .NRD(NR), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_a), .rbusy(rbusy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
    );

    regfile_mp_sb #(.ADDR_W(AW), .DATA_W(DW), .NRD(NR), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] a);
        if (rst) return '0;
        if (k == 0 && a == '0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return mm[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input logic [AW-1:0] a);
        if (rst) return 1'b0;
        if (k == 0 && a == '0) return 1'b0;
        if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
        return bb[k][a];
    endfunction

    function automatic logic [DW-1:0] exp_dbg(input int k);
        if (rst) return '0;
        if (k == 0 && dbg_addr == '0) return '0;
        return mm[k][dbg_addr];
    endfunction

    task automatic check_all();
        logic [AW-1:0] a;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NR; p++) begin
                a = ra[p*AW +: AW];
                chk($sformatf("rd k%0d p%0d", k, p),
                    (k == 0) ? rd_a[p*DW +: DW] : rd_b[p*DW +: DW], exp_rd(k, a));
                chk($sformatf("rbusy k%0d p%0d", k, p),
                    {31'b0, (k == 0) ? rbusy_a[p] : rbusy_b[p]}, {31'b0, exp_busy(k, a)});
            end
            chk($sformatf("dbg k%0d", k), (k == 0) ? dbg_a : dbg_b, exp_dbg(k));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) begin
                mm[k][a] = '0;
                bb[k][a] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (we0) begin mm[k][wa0] = wd0; bb[k][wa0] = 1'b0; end
            if (we1) begin mm[k][wa1] = wd1; bb[k][wa1] = 1'b0; end
            if (iss_en) bb[k][iss_addr] = 1'b1;
            if (k == 0) begin mm[0][0] = '0; bb[0][0] = 1'b0; end
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_en = 0;
        wa0 = '0; wa1 = '0; iss_addr = '0;
        wd0 = '0; wd1 = '0;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    // Entered at posedge+1; returns at the next posedge+1 with the model advanced.
    task automatic cycle();
        #3 check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        ra = '0;
        dbg_addr = '0;
        model_reset();

        // reset state, including writes presented while in reset
        we0 = 1; wa0 = 5'd4; wd0 = 32'hCAFE_0001; set_ra(0, 5'd4);
        #1 check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 0;
        idle();
        ra = '0;

        // write-through bypass
        we0 = 1; wa0 = 5'd7; wd0 = 32'h1234; set_ra(2, 5'd7);
        #3 chk("bypass_rd2", rd_a[2*DW +: DW], 32'h1234);
        cycle();
        idle(); dbg_addr = 5'd7;
        #3 chk("bypass_dbg7", dbg_a, 32'h1234);
        cycle();

        // write collision
        we0 = 1; wa0 = 5'd3; wd0 = 32'h11;
        we1 = 1; wa1 = 5'd3; wd1 = 32'h22;
        set_ra(0, 5'd3);
        #3 chk("collide_rd", rd_a[DW-1:0], 32'h22);
        cycle();
        idle(); dbg_addr = 5'd3;
        #3 chk("collide_dbg", dbg_a, 32'h22);
        cycle();

        // zero register
        we0 = 1; wa0 = '0; wd0 = 32'hFFFF_FFFF; iss_en = 1; iss_addr = '0;
        ra = '0; dbg_addr = '0;
        #3 chk("zero_rd_a", rd_a[DW-1:0], 32'h0);
        cycle();
        idle();
        #3 chk("zero_rd_b", rd_b[DW-1:0], 32'hFFFF_FFFF);
        chk("zero_busy_a", {29'b0, rbusy_a}, 32'h0);
        cycle();

        // scoreboard set / clear
        iss_en = 1; iss_addr = 5'd9;
        cycle();
        idle(); set_ra(1, 5'd9);
        #3 chk("sb_busy", {31'b0, rbusy_a[1]}, 32'h1);
        cycle();
        we1 = 1; wa1 = 5'd9; wd1 = 32'hAB;
        #3 chk("sb_wb_busy", {31'b0, rbusy_a[1]}, 32'h0);
        cycle();
        idle();
        #3 chk("sb_cleared", {31'b0, rbusy_a[1]}, 32'h0);
        cycle();

        // issue beats same-cycle write-back
        iss_en = 1; iss_addr = 5'd9;
        cycle();
        iss_en = 1; iss_addr = 5'd9; we0 = 1; wa0 = 5'd9; wd0 = 32'h5;
        #3 chk("iss_wb_rd", rd_a[DW +: DW], 32'h5);
        chk("iss_wb_busy", {31'b0, rbusy_a[1]}, 32'h0);
        cycle();
        idle();
        #3 chk("iss_wb_next", {31'b0, rbusy_a[1]}, 32'h1);
        cycle();

        // randomised traffic
        repeat (400) begin
            we0 = 1'($urandom_range(0, 1)); wa0 = rnd_addr(); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = rnd_addr(); wd1 = $urandom;
            iss_en = ($urandom_range(0, 2) == 0); iss_addr = rnd_addr();
            for (int p = 0; p < NR; p++) set_ra(p, rnd_addr());
            dbg_addr = rnd_addr();
            cycle();
        end

        // asynchronous reset mid-cycle
        idle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; iss_en = 1; iss_addr = 5'd5;
        cycle();
        idle(); set_ra(0, 5'd5); dbg_addr = 5'd5;
        #2 chk("pre_rst_rd", rd_a[DW-1:0], 32'hDEAD_BEEF);
        chk("pre_rst_busy", {31'b0, rbusy_a[0]}, 32'h1);
        #1 rst = 1;
        model_reset();
        #1 chk("rst_rd", rd_a[DW-1:0], 32'h0);
        chk("rst_busy", {31'b0, rbusy_a[0]}, 32'h0);
        chk("rst_dbg", dbg_a, 32'h0);
        we0 = 1; wa0 = 5'd5; wd0 = 32'h7777;
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        rst = 0;
        idle();
        #1 check_all();
        we1 = 1; wa1 = 5'd5; wd1 = 32'h3C3C;
        cycle();
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
